lm70_dual_scheduler: RTL

- Sequencer and arbiter that shares one SPI read bus (SCK, SIO) between two LM70-class temperature sensors, each with its own active-low chip select.
- Round-robin scheduling at a fixed frame period; generates CS/SCK, deserialises SIO, latches per-sensor temperature words and raises per-sensor over-temperature alarms with hysteresis.
- Sits between the top-level uio pins and the BCD/display datapath; replaces single-sensor free-running read sequencing.

---
 rtl/lm70_dual_scheduler.sv | 133 +++++++++++++
 1 files changed

// File: rtl/lm70_dual_scheduler.sv
// Round-robin read sequencer sharing one SPI read bus between two LM70-class sensors.
// Generates CS/SCK, deserialises SIO, latches per-sensor temperatures and hysteretic alarms.
module lm70_dual_scheduler #(
  parameter int unsigned NBITS     = 8,
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned HOLD_CYC  = 2,
  parameter int unsigned PERIOD    = 32,
  parameter int unsigned HYST      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       sens_en,
  input  logic [NBITS-1:0] thr,
  input  logic             sio,
  output logic             sck,
  output logic [1:0]       cs_n,
  output logic [NBITS-1:0] temp0,
  output logic [NBITS-1:0] temp1,
  output logic [1:0]       valid,
  output logic [1:0]       alarm,
  output logic             busy,
  output logic             cur_sel
);

  localparam int unsigned FrameLen = SETUP_CYC + 2 * NBITS + HOLD_CYC + 1;
  localparam int unsigned PMax     = (PERIOD > FrameLen) ? PERIOD : FrameLen;
  localparam int unsigned PW       = $clog2(PMax + 2);
  localparam int unsigned CW       = $clog2(SETUP_CYC + HOLD_CYC + 1);
  localparam int unsigned BW       = $clog2(NBITS + 1);

  typedef enum logic [2:0] {StIdle, StCsSetup, StShift, StCsHold, StLatch, StWait} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [BW-1:0]    bit_q;
  logic [PW-1:0]    pcnt_q;
  logic [NBITS-1:0] sr_q;

  logic [NBITS-1:0] temp_new;
  logic             grant;
  logic             alarm_next;

  always_comb begin
    // Sign bit is dropped and the LSB forced low to form the reported word.
    temp_new   = {sr_q[NBITS-2:0], 1'b0};
    grant      = sens_en[~cur_sel] ? ~cur_sel : cur_sel;
    alarm_next = alarm[cur_sel];
    if (temp_new >= thr) begin
      alarm_next = 1'b1;
    end else if (({1'b0, temp_new} + (NBITS + 1)'(HYST)) < {1'b0, thr}) begin
      alarm_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cs_n    <= 2'b11;
      sck     <= 1'b0;
      temp0   <= '0;
      temp1   <= '0;
      valid   <= '0;
      alarm   <= '0;
      busy    <= 1'b0;
      cur_sel <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      pcnt_q  <= '0;
      sr_q    <= '0;
    end else begin
      valid <= '0;
      if (state_q != StIdle) pcnt_q <= pcnt_q + PW'(1);
      unique case (state_q)
        StIdle: begin
          if (en && (sens_en != 2'b00)) begin
            cur_sel <= grant;
            pcnt_q  <= '0;
            cnt_q   <= '0;
            cs_n    <= grant ? 2'b01 : 2'b10;
            busy    <= 1'b1;
            state_q <= StCsSetup;
          end
        end
        StCsSetup: begin
          if (cnt_q == CW'(SETUP_CYC - 1)) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= StShift;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        StShift: begin
          if (!sck) begin
            sck <= 1'b1;
          end else begin
            sck   <= 1'b0;
            sr_q  <= {sr_q[NBITS-2:0], sio};
            bit_q <= bit_q + BW'(1);
            if (bit_q == BW'(NBITS - 1)) begin
              cs_n    <= 2'b11;
              cnt_q   <= '0;
              state_q <= StCsHold;
            end
          end
        end
        StCsHold: begin
          if (cnt_q == CW'(HOLD_CYC - 1)) begin
            cnt_q   <= '0;
            state_q <= StLatch;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        StLatch: begin
          if (cur_sel) temp1 <= temp_new;
          else         temp0 <= temp_new;
          valid[cur_sel] <= 1'b1;
          alarm[cur_sel] <= alarm_next;
          busy           <= 1'b0;
          state_q        <= StWait;
        end
        StWait: begin
          // Next frame starts PERIOD cycles after this one, or right away if the frame ran longer.
          if ((32'(pcnt_q) + 32'd2) >= PERIOD) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
